// File: rtl/uart_rx_core_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : uart_rx_core_if                                               |
// | Description: RX-side bus between uart_rx_core and uart_ctl.                |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface uart_rx_core_if;
  logic       rx_en;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_break;
  logic       rx_err;
  logic       rx_busy;

  // master = uart_ctl side, slave = receive engine
  modport master (
    output rx_en,
    input  rx_valid, rx_data, rx_break, rx_err, rx_busy
  );

  modport slave (
    input  rx_en,
    output rx_valid, rx_data, rx_break, rx_err, rx_busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : uart_rx_core                                                  |
// | Description: Oversampling UART receiver, 8N1 framing (8E1 when             |
// |              UART_RX_PARITY_EN is defined).                                |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_in,
  uart_rx_core_if.slave   bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_HOLD   = 3'd5;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       idx_q,   idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q,  data_d;
  logic             valid_q, valid_d;
  logic             err_q,   err_d;
  logic             break_q, break_d;
  logic             rxs;
  logic             par_ok;
  logic             par_zero;

`ifdef UART_RX_PARITY_EN
  logic             parity_q, parity_d;
  assign par_ok   = ~(^{shift_q, parity_q});
  assign par_zero = ~parity_q;
`else
  assign par_ok   = 1'b1;
  assign par_zero = 1'b1;
`endif

  assign rxs = sync2_q;

  always_comb begin
    sync1_d  = rx_in;
    sync2_d  = sync1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    break_d  = break_q;
`ifdef UART_RX_PARITY_EN
    parity_d = parity_q;
`endif

    if (!bus.rx_en) begin
      // Disabling abandons any partial frame; the last good byte is kept.
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      break_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          idx_d = '0;
          if (!rxs) begin
            state_d = ST_START;
          end
        end

        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = rxs ? ST_IDLE : ST_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (cnt_q == FULL_LAST) begin
            cnt_d   = '0;
            shift_d = {rxs, shift_q[7:1]};
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_q == FULL_LAST) begin
            cnt_d    = '0;
            parity_d = rxs;
            state_d  = ST_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (cnt_q == FULL_LAST) begin
            cnt_d = '0;
            if (rxs) begin
              state_d = ST_IDLE;
              if (par_ok) begin
                data_d  = shift_q;
                valid_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end else if ((shift_q == 8'h00) && par_zero) begin
              break_d = 1'b1;
              state_d = ST_HOLD;
            end else begin
              // Framing error outranks parity; both report through rx_err.
              err_d   = 1'b1;
              state_d = ST_HOLD;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_HOLD: begin
          // A line still held low must not be mistaken for the next start bit.
          cnt_d = '0;
          if (rxs) begin
            break_d = 1'b0;
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= 8'h00;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      break_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      break_q  <= break_d;
`ifdef UART_RX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.rx_valid = valid_q;
  assign bus.rx_data  = data_q;
  assign bus.rx_break = break_q;
  assign bus.rx_err   = err_q;
  assign bus.rx_busy  = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_uart_rx_core                                               |
// | Description: Randomized self-checking bench for uart_rx_core against a     |
// |              sample-time frame model (honours UART_RX_PARITY_EN).          |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_uart_rx_core;
  localparam int C = 16;
  localparam int H = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NSAMP = 10;
`else
  localparam int NSAMP = 9;
`endif
  // rx_in change -> rx_valid: 2 sync cycles + half bit + NSAMP bits + 1
  localparam int LAT = 2 + H + NSAMP * C + 1;

  logic clk = 1'b0;
  logic rst;
  logic rx_in;
  uart_rx_core_if u_if ();

  always #5 clk = ~clk;

  uart_rx_core #(.CLKS_PER_BIT(C), .HALF_BIT(H)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_in (rx_in),
    .bus   (u_if)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic comp_en = 1'b0;
  int last_valid_cyc = -1;
  int n_valid = 0;
  int n_err = 0;

  // Frame model: a start time t0 plus arithmetic on (cycle - t0).
  logic       m_s1, m_s2, m_rxs;
  int         m_mode;  // 0 idle, 1 in frame, 2 waiting for line high
  int         m_t0, m_k, m_n;
  logic [7:0] m_shift, m_data;
  logic       m_par, m_break, m_valid, m_err, m_good_par;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    m_rxs = m_s2;
    if (rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_mode = 0; m_shift = 8'h00; m_data = 8'h00;
      m_par = 1'b0; m_break = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    end else begin
      m_s2 = m_s1;
      m_s1 = rx_in;
      m_valid = 1'b0;
      m_err = 1'b0;
      if (!u_if.rx_en) begin
        m_mode = 0;
        m_break = 1'b0;
      end else if (m_mode == 0) begin
        if (!m_rxs) begin
          m_mode = 1;
          m_t0 = cyc;
        end
      end else if (m_mode == 1) begin
        m_k = cyc - m_t0;
        if (m_k == H) begin
          if (m_rxs) m_mode = 0;
        end else if (m_k > H && ((m_k - H) % C) == 0) begin
          m_n = (m_k - H) / C;
          if (m_n <= 8) begin
            m_shift[m_n-1] = m_rxs;
          end else if (m_n < NSAMP) begin
            m_par = m_rxs;
          end else begin
`ifdef UART_RX_PARITY_EN
            m_good_par = ((^m_shift) == m_par);
`else
            m_good_par = 1'b1;
`endif
            if (m_rxs) begin
              m_mode = 0;
              if (m_good_par) begin
                m_data = m_shift;
                m_valid = 1'b1;
              end else begin
                m_err = 1'b1;
              end
            end else if (m_shift == 8'h00 && !m_par) begin
              m_break = 1'b1;
              m_mode = 2;
            end else begin
              m_err = 1'b1;
              m_mode = 2;
            end
          end
        end
      end else begin
        if (m_rxs) begin
          m_break = 1'b0;
          m_mode = 0;
        end
      end
    end
    cyc++;
  end

  always @(posedge clk) begin
    #1;
    if (comp_en) begin
      check("rx_valid", 32'(u_if.rx_valid), 32'(m_valid));
      check("rx_err",   32'(u_if.rx_err),   32'(m_err));
      check("rx_data",  32'(u_if.rx_data),  32'(m_data));
      check("rx_break", 32'(u_if.rx_break), 32'(m_break));
      check("rx_busy",  32'(u_if.rx_busy),  32'(m_mode != 0));
      if (u_if.rx_valid === 1'b1) begin
        last_valid_cyc = cyc;
        n_valid++;
      end
      if (u_if.rx_err === 1'b1) n_err++;
    end
  end

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; abort >= 0 drops rx_en at that cycle offset of the frame.
  task automatic send(input logic [7:0] b, input logic par, input logic stop,
                      input int stop_len, input int abort, output int start_cyc);
    int bi;
    start_cyc = cyc;
    for (int c = 0; c < C * NSAMP + stop_len; c++) begin
      bi = c / C;
      if (c == abort) u_if.rx_en = 1'b0;
      if (bi == 0)          rx_in = 1'b0;
      else if (bi <= 8)     rx_in = b[bi-1];
      else if (bi < NSAMP)  rx_in = par;
      else                  rx_in = stop;
      @(negedge clk);
    end
    rx_in = 1'b1;
    if (!u_if.rx_en) begin
      repeat (4) @(negedge clk);
      u_if.rx_en = 1'b1;
    end
  endtask

  int s, nv, ne, kind;
  logic [7:0] rb;
  logic rp;

  initial begin
    rst = 1'b1;
    rx_in = 1'b1;
    u_if.rx_en = 1'b1;
    repeat (5) @(negedge clk);
    check("reset rx_valid", 32'(u_if.rx_valid), 32'd0);
    check("reset rx_data",  32'(u_if.rx_data),  32'h00);
    check("reset rx_break", 32'(u_if.rx_break), 32'd0);
    check("reset rx_err",   32'(u_if.rx_err),   32'd0);
    check("reset rx_busy",  32'(u_if.rx_busy),  32'd0);
    rst = 1'b0;
    comp_en = 1'b1;
    idle(20);

    // Two back-to-back good frames with literal timing
    send(8'hA5, ^8'hA5, 1'b1, C, -1, s);
    check("A5 valid cycle", 32'(last_valid_cyc), 32'(s + LAT));
    check("A5 data", 32'(u_if.rx_data), 32'hA5);
    send(8'h3C, ^8'h3C, 1'b1, C, -1, s);
    check("3C valid cycle", 32'(last_valid_cyc), 32'(s + LAT));
    check("3C data", 32'(u_if.rx_data), 32'h3C);
    idle(2 * C);

    // Short glitch rejected by the start-bit check
    nv = n_valid; ne = n_err;
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    idle(2 * C);
    check("glitch busy", 32'(u_if.rx_busy), 32'd0);
    check("glitch strobes", 32'(n_valid + n_err), 32'(nv + ne));

    // Stop bit held low for two bit times -> single framing error
    nv = n_valid; ne = n_err;
    send(8'h3C, ^8'h3C, 1'b0, 2 * C, -1, s);
    idle(2 * C);
    check("ferr count", 32'(n_err), 32'(ne + 1));
    check("ferr no valid", 32'(n_valid), 32'(nv));
    check("ferr data held", 32'(u_if.rx_data), 32'h3C);

    // Break: 20 bit times low, clears a few cycles after the line rises
    nv = n_valid; ne = n_err;
    rx_in = 1'b0;
    repeat (20 * C) @(negedge clk);
    check("break set", 32'(u_if.rx_break), 32'd1);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    check("break held", 32'(u_if.rx_break), 32'd1);
    @(negedge clk);
    check("break cleared", 32'(u_if.rx_break), 32'd0);
    check("break no strobes", 32'(n_valid + n_err), 32'(nv + ne));
    idle(2 * C);

    // Drop rx_en during bit 4 of 0xFF, then a clean 0x12
    nv = n_valid; ne = n_err;
    rx_in = 1'b0;
    repeat (C) @(negedge clk);
    rx_in = 1'b1;
    repeat (4 * C + C / 2) @(negedge clk);
    u_if.rx_en = 1'b0;
    @(negedge clk);
    check("disable busy", 32'(u_if.rx_busy), 32'd0);
    repeat (5 * C) @(negedge clk);
    u_if.rx_en = 1'b1;
    idle(4);
    check("disable no strobes", 32'(n_valid + n_err), 32'(nv + ne));
    send(8'h12, ^8'h12, 1'b1, C, -1, s);
    check("12 data", 32'(u_if.rx_data), 32'h12);
    idle(C);

`ifdef UART_RX_PARITY_EN
    send(8'h81, 1'b0, 1'b1, C, -1, s);
    check("81 even valid", 32'(last_valid_cyc), 32'(s + LAT));
    check("81 data", 32'(u_if.rx_data), 32'h81);
    ne = n_err; nv = n_valid;
    send(8'h81, 1'b1, 1'b1, C, -1, s);
    idle(C);
    check("81 parity err", 32'(n_err), 32'(ne + 1));
    check("81 parity no valid", 32'(n_valid), 32'(nv));
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      rb = 8'($urandom);
      rp = ^rb;
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        rx_in = 1'b0;
        repeat ($urandom_range(1, H - 2)) @(negedge clk);
        idle(C);
      end else if (kind == 1) begin
        send(rb, rp, 1'b0, int'($urandom_range(C, 3 * C)), -1, s);
      end else if (kind == 2) begin
        send(rb, rp, 1'b1, C, int'($urandom_range(1, C * NSAMP - 1)), s);
      end else begin
        if ($urandom_range(0, 9) == 0) rp = ~rp;
        send(rb, rp, 1'b1, C, -1, s);
      end
      idle(int'($urandom_range(0, C)));
    end
    idle(3 * C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
